alu_ctrl_seq: RTL and testbench

- Registered, handshaked successor to the combinational ALU control decoder; sits between the ID stage and the EX-stage ALU.
- Decodes ALUOp/ALUF into the ALU op select plus special-op flags. Registers the result with valid/stall/flush control.
- When SERIAL_SHIFT=1, breaks shift/rotate ops into shamt single-bit beats so the EX stage can use a 1-bit shifter.

---
 rtl/alu_ctrl_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder between ID and EX.
// Optionally splits shift/rotate ops into 1-bit beats.
module alu_ctrl_seq #(
    parameter int SERIAL_SHIFT = 1,
    parameter int SHAMT_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ALUOp,
    input  logic [1:0]         ALUF,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    input  logic               stall,
    output logic               out_valid,
    output logic [3:0]         opOut,
    output logic               invB,
    output logic               immPass,
    output logic               doSLE,
    output logic               doSEQ,
    output logic               doSCO,
    output logic               doBTR,
    output logic               doSLBI,
    output logic               doSLT,
    output logic               doSTU,
    output logic               shStep,
    output logic               shLast,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, HOLD, SHIFT} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       invb;
        logic       imm;
        logic       sle;
        logic       seq;
        logic       sco;
        logic       btr;
        logic       slbi;
        logic       slt;
        logic       stu;
        logic       err;
    } dec_t;

    state_t             state, state_n;
    dec_t               dec, r, r_n;
    logic               vld, vld_n;
    logic               step, step_n;
    logic               last, last_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic               dec_sh, tbl, serial, acc;

    always_comb begin
        dec    = '0;
        dec_sh = 1'b0;
        tbl    = 1'b1;
        unique case (ALUOp)
            5'b01000, 5'b10000, 5'b10001, 5'b10011,
            5'b11001, 5'b11111, 5'b00101: dec.op = 4'b0100;
            5'b01001: dec.op = 4'b1000;
            5'b01010: dec.op = 4'b0101;
            5'b01011: dec.op = 4'b0110;
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                dec.op = {2'b00, ALUOp[1:0]};
                dec_sh = 1'b1;
            end
            5'b11010: begin
                dec.op = {2'b00, ALUF};
                dec_sh = 1'b1;
            end
            5'b11011: begin
                unique case (ALUF)
                    2'b00:   dec.op = 4'b0100;
                    2'b01:   dec.op = 4'b1000;
                    2'b10:   dec.op = 4'b0101;
                    default: dec.op = 4'b0110;
                endcase
            end
            5'b11100, 5'b11101, 5'b11110, 5'b01100,
            5'b01101, 5'b01110, 5'b01111: dec.op = 4'b0111;
            // lbi and slbi carry only a flag; the ALU op stays 0000
            5'b11000, 5'b10010: dec.op = 4'b0000;
            default: tbl = 1'b0;
        endcase
        dec.invb = (ALUOp == 5'b01011) |
                   ((ALUOp == 5'b11011) & (ALUF == 2'b11));
        dec.imm  = ALUOp == 5'b11000;
        dec.sle  = ALUOp == 5'b11110;
        dec.seq  = ALUOp == 5'b11100;
        dec.sco  = ALUOp == 5'b11111;
        dec.btr  = ALUOp == 5'b11001;
        dec.slbi = ALUOp == 5'b10010;
        dec.slt  = ALUOp == 5'b11101;
        dec.stu  = ALUOp == 5'b10011;
        dec.err  = !tbl;
    end

    assign serial = (SERIAL_SHIFT != 0) && dec_sh && (shamt != '0);

    // The final shift beat frees the slot in the cycle it is consumed
    assign in_ready = !rst && !flush &&
                      ((state == SHIFT) ? (last && !stall)
                                        : (!vld || !stall));
    assign acc = in_valid && in_ready;

    always_comb begin
        state_n = state;
        r_n     = r;
        vld_n   = vld;
        step_n  = step;
        last_n  = last;
        cnt_n   = cnt;
        if (flush) begin
            state_n = IDLE;
            vld_n   = 1'b0;
            step_n  = 1'b0;
            last_n  = 1'b0;
            cnt_n   = '0;
        end else if (acc) begin
            r_n   = dec;
            vld_n = 1'b1;
            if (serial) begin
                state_n = SHIFT;
                cnt_n   = shamt;
                step_n  = 1'b1;
                last_n  = shamt == SHAMT_W'(1);
            end else begin
                state_n = HOLD;
                cnt_n   = '0;
                step_n  = 1'b0;
                last_n  = 1'b0;
            end
        end else if (!stall) begin
            unique case (state)
                HOLD: begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                end
                SHIFT: begin
                    if (cnt == SHAMT_W'(1)) begin
                        state_n = IDLE;
                        vld_n   = 1'b0;
                        step_n  = 1'b0;
                        last_n  = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n  = cnt - SHAMT_W'(1);
                        last_n = cnt == SHAMT_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            vld   <= 1'b0;
            step  <= 1'b0;
            last  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            vld   <= vld_n;
            step  <= step_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    assign out_valid = vld;
    assign opOut     = r.op;
    assign invB      = r.invb;
    assign immPass   = r.imm;
    assign doSLE     = r.sle;
    assign doSEQ     = r.seq;
    assign doSCO     = r.sco;
    assign doBTR     = r.btr;
    assign doSLBI    = r.slbi;
    assign doSLT     = r.slt;
    assign doSTU     = r.stu;
    assign err       = r.err;
    assign shStep    = step;
    assign shLast    = last;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed scenarios plus random
// traffic against a queue-of-beats reference model.
module tb_alu_ctrl_seq;

    localparam int SW  = 4;
    localparam bit SER = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    ALUOp = '0;
    logic [1:0]    ALUF = '0;
    logic [SW-1:0] shamt = '0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          out_valid;
    logic [3:0]    opOut;
    logic          invB, immPass, doSLE, doSEQ, doSCO;
    logic          doBTR, doSLBI, doSLT, doSTU;
    logic          shStep, shLast, err;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.SERIAL_SHIFT(1), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .ALUF(ALUF), .shamt(shamt),
        .flush(flush), .stall(stall),
        .out_valid(out_valid), .opOut(opOut),
        .invB(invB), .immPass(immPass), .doSLE(doSLE),
        .doSEQ(doSEQ), .doSCO(doSCO), .doBTR(doBTR),
        .doSLBI(doSLBI), .doSLT(doSLT), .doSTU(doSTU),
        .shStep(shStep), .shLast(shLast), .err(err)
    );

    wire [15:0] obs = {opOut, invB, immPass, doSLE, doSEQ,
                       doSCO, doBTR, doSLBI, doSLT, doSTU,
                       err, shStep, shLast};

    int total = 0;
    int bad   = 0;
    bit last_rst = 1'b0;
    logic [15:0] q[$];

    logic [4:0] ops [27] = '{
        5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10100,
        5'b10101, 5'b10110, 5'b10111, 5'b10000, 5'b10001,
        5'b10011, 5'b11001, 5'b10010, 5'b11011, 5'b11010,
        5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b01100,
        5'b01101, 5'b01110, 5'b01111, 5'b00101, 5'b11000,
        5'b11010, 5'b10101};

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ref_dec(logic [4:0] a,
                                            logic [1:0] f);
        logic [3:0] op;
        bit known;
        op    = 4'b0000;
        known = 1'b1;
        if (a inside {5'b01000, 5'b10000, 5'b10001, 5'b10011,
                      5'b11001, 5'b11111, 5'b00101})
            op = 4'b0100;
        else if (a == 5'b01001) op = 4'b1000;
        else if (a == 5'b01010) op = 4'b0101;
        else if (a == 5'b01011) op = 4'b0110;
        else if (a == 5'b10100) op = 4'b0000;
        else if (a == 5'b10101) op = 4'b0001;
        else if (a == 5'b10110) op = 4'b0010;
        else if (a == 5'b10111) op = 4'b0011;
        else if (a == 5'b11011)
            op = (f == 2'd0) ? 4'b0100 :
                 (f == 2'd1) ? 4'b1000 :
                 (f == 2'd2) ? 4'b0101 : 4'b0110;
        else if (a == 5'b11010)
            op = (f == 2'd0) ? 4'b0000 :
                 (f == 2'd1) ? 4'b0001 :
                 (f == 2'd2) ? 4'b0010 : 4'b0011;
        else if (a inside {5'b11100, 5'b11101, 5'b11110,
                           5'b01100, 5'b01101, 5'b01110,
                           5'b01111})
            op = 4'b0111;
        else if (!(a inside {5'b11000, 5'b10010}))
            known = 1'b0;
        return {op,
                a == 5'b01011 || (a == 5'b11011 && f == 2'd3),
                a == 5'b11000, a == 5'b11110, a == 5'b11100,
                a == 5'b11111, a == 5'b11001, a == 5'b10010,
                a == 5'b11101, a == 5'b10011, !known};
    endfunction

    function automatic bit ref_sh(logic [4:0] a);
        return a inside {5'b10100, 5'b10101, 5'b10110,
                         5'b10111, 5'b11010};
    endfunction

    task automatic cyc(bit v, logic [4:0] a, logic [1:0] f,
                       logic [SW-1:0] n, bit st, bit fl, bit r);
        logic [13:0] d;
        bit rdy;
        @(negedge clk);
        if (last_rst)
            chk("reset", {out_valid, obs}, 32'd0);
        if (q.size() == 0) begin
            chk("idle", {out_valid, shStep, shLast}, 32'd0);
        end else begin
            chk("valid", out_valid, 32'd1);
            chk("outs", obs, q[0]);
        end
        in_valid = v;
        ALUOp    = a;
        ALUF     = f;
        shamt    = n;
        stall    = st;
        flush    = fl;
        rst      = r;
        #1;
        rdy = !r && !fl &&
              (q.size() == 0 || (q.size() == 1 && !st));
        chk("ready", in_ready, rdy);
        if (r || fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !st)
                void'(q.pop_front());
            if (v && rdy) begin
                d = ref_dec(a, f);
                if (SER && ref_sh(a) && n != 0) begin
                    for (int i = 0; i < int'(n); i++)
                        q.push_back({d, 1'b1,
                                     i == int'(n) - 1});
                end else begin
                    q.push_back({d, 2'b00});
                end
            end
        end
        last_rst = r;
    endtask

    task automatic idle_cyc(bit st);
        cyc(1'b0, 5'b0, 2'b0, '0, st, 1'b0, 1'b0);
    endtask

    initial begin
        cyc(0, 5'b0, 2'b0, 0, 0, 0, 1);
        // R-type sub, then back-to-back andni
        cyc(1, 5'b11011, 2'b01, 0, 0, 0, 0);
        cyc(1, 5'b01011, 2'b00, 0, 0, 0, 0);
        repeat (3) cyc(1, 5'b01000, 2'b00, 0, 1, 0, 0);
        cyc(1, 5'b01000, 2'b00, 0, 0, 0, 0);
        // slli by 3, stall on beat 2, srl shamt=0 back-to-back
        cyc(1, 5'b10101, 2'b00, 3, 0, 0, 0);
        idle_cyc(0);
        idle_cyc(1);
        idle_cyc(0);
        cyc(1, 5'b11010, 2'b11, 0, 0, 0, 0);
        idle_cyc(0);
        idle_cyc(0);
        // flush on beat 2 of a 5-beat shift with a new op offered
        cyc(1, 5'b10101, 2'b00, 5, 0, 0, 0);
        idle_cyc(0);
        cyc(1, 5'b01000, 2'b00, 0, 0, 1, 0);
        idle_cyc(0);
        // undecodable op, reset while held
        cyc(1, 5'b00000, 2'b00, 0, 0, 0, 0);
        idle_cyc(1);
        cyc(0, 5'b0, 2'b0, 0, 1, 0, 1);
        idle_cyc(0);
        // longest shift
        cyc(1, 5'b10110, 2'b00, 4'hf, 0, 0, 0);
        repeat (17) idle_cyc(0);
        for (int k = 0; k < 3000; k++) begin
            logic [4:0] a;
            logic [SW-1:0] n;
            a = ($urandom_range(0, 4) != 0)
                ? ops[$urandom_range(0, 26)]
                : 5'($urandom);
            n = ($urandom_range(0, 3) == 0)
                ? SW'($urandom) : SW'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) != 0, a, 2'($urandom), n,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 99) == 0);
        end
        repeat (20) idle_cyc(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
